// File: rtl/color_pkg.sv
// Shared types and constants for the round colour sequencer.
// Colour codes, slot indices and the round FSM states.
package color_pkg;

  localparam int COLOR_W    = 3;
  localparam int NUM_SLOTS  = 4;
  localparam int NUM_COLORS = 1 << COLOR_W;
  localparam int SLOT_W     = $clog2(NUM_SLOTS);

  localparam logic [COLOR_W-1:0] COLOR_BLACK = 3'b000;

  typedef logic [COLOR_W-1:0]    color_t;
  typedef logic [SLOT_W-1:0]     slot_t;
  typedef logic [NUM_COLORS-1:0] cmask_t;

  typedef enum logic [2:0] {
    IDLE,
    DRAW_BALL,
    DRAW_SLOT,
    DRAW_PLAT,
    PUBLISH
  } round_state_t;

endpackage

// File: rtl/color_fallback_pick.sv
// Judges a candidate colour and finds the lowest legal fallback.
// Legal: not black, not the ball colour, not in the used mask.
module color_fallback_pick
  import color_pkg::*;
(
  input  logic [COLOR_W-1:0]    cand_i,
  input  logic [COLOR_W-1:0]    ball_i,
  input  logic [NUM_COLORS-1:0] used_i,
  output logic                  ok_o,
  output logic [COLOR_W-1:0]    fb_o
);

  assign ok_o = (cand_i != COLOR_BLACK)
             && (cand_i != ball_i)
             && !used_i[cand_i];

  // Scan downward so the lowest legal colour is the last one written.
  always_comb begin
    fb_o = COLOR_BLACK;
    for (int c = NUM_COLORS - 1; c > 0; c--) begin
      if ((color_t'(c) != ball_i) && !used_i[c]) begin
        fb_o = color_t'(c);
      end
    end
  end

endmodule

// File: rtl/color_round_ctrl.sv
// Round colour sequencer: ball, ball slot, three platform colours.
// Optional COLOR_DISTINCT_EN keeps platform colours mutually distinct.
module color_round_ctrl
  import color_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 7
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           round_req,
  input  logic [7:0]                     rand_in,
  output logic                           rand_step,
  output logic [COLOR_W-1:0]             ball_color,
  output logic [NUM_SLOTS*COLOR_W-1:0]   plat_colors,
  output logic                           colors_valid,
  output logic                           busy,
  output logic                           round_ack
);

  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);
  localparam logic [1:0] LAST_PLAT = 2'(NUM_SLOTS - 2);

  typedef logic [NUM_SLOTS-1:0][COLOR_W-1:0] plats_t;

  round_state_t state_q, state_d;
  logic [3:0]   retry_q, retry_d;
  color_t       ball_sh_q, ball_sh_d;
  slot_t        slot_q, slot_d;
  plats_t       plat_sh_q, plat_sh_d;
  cmask_t       used_q, used_d;
  slot_t        idx_q, idx_d;
  logic [1:0]   cnt_q, cnt_d;
  color_t       ball_q, ball_d;
  plats_t       plat_q, plat_d;
  logic         valid_q, valid_d;

  logic   in_plat;
  color_t pick_cand;
  color_t pick_ball;
  cmask_t pick_used;
  logic   pick_ok;
  color_t pick_fb;
  logic   take;
  color_t take_col;
  slot_t  idx_inc;
  slot_t  idx_nxt;

  assign in_plat   = (state_q == DRAW_PLAT);
  assign pick_cand = in_plat ? rand_in[5:3] : rand_in[2:0];
  assign pick_ball = in_plat ? ball_sh_q : COLOR_BLACK;
  assign pick_used = in_plat ? used_q : '0;

  color_fallback_pick u_pick (
    .cand_i (pick_cand),
    .ball_i (pick_ball),
    .used_i (pick_used),
    .ok_o   (pick_ok),
    .fb_o   (pick_fb)
  );

  assign take     = pick_ok || (retry_q == RETRY_LIM);
  assign take_col = pick_ok ? pick_cand : pick_fb;
  assign idx_inc  = idx_q + slot_t'(1);
  assign idx_nxt  = (idx_inc == slot_q) ? idx_inc + slot_t'(1)
                                        : idx_inc;

  assign rand_step    = (state_q == DRAW_BALL)
                     || (state_q == DRAW_SLOT)
                     || (state_q == DRAW_PLAT);
  assign busy         = (state_q != IDLE);
  assign round_ack    = (state_q == PUBLISH);
  assign ball_color   = ball_q;
  assign plat_colors  = plat_q;
  assign colors_valid = valid_q;

  // Next-state logic: draws fill the shadow set, last accept publishes.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    ball_sh_d = ball_sh_q;
    slot_d    = slot_q;
    plat_sh_d = plat_sh_q;
    used_d    = used_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ball_d    = ball_q;
    plat_d    = plat_q;
    valid_d   = valid_q;
    unique case (state_q)
      IDLE: begin
        if (round_req) begin
          state_d = DRAW_BALL;
          retry_d = '0;
          used_d  = '0;
        end
      end
      DRAW_BALL: begin
        if (take) begin
          ball_sh_d = take_col;
          retry_d   = '0;
          state_d   = DRAW_SLOT;
        end else begin
          retry_d = retry_q + 4'd1;
        end
      end
      DRAW_SLOT: begin
        slot_d            = rand_in[7:6];
        plat_sh_d[slot_d] = ball_sh_q;
        idx_d   = (rand_in[7:6] == '0) ? slot_t'(1) : '0;
        cnt_d   = '0;
        state_d = DRAW_PLAT;
      end
      DRAW_PLAT: begin
        if (take) begin
          plat_sh_d[idx_q] = take_col;
`ifdef COLOR_DISTINCT_EN
          used_d[take_col] = 1'b1;
`endif
          retry_d = '0;
          cnt_d   = cnt_q + 2'd1;
          idx_d   = idx_nxt;
          if (cnt_q == LAST_PLAT) begin
            ball_d  = ball_sh_q;
            plat_d  = plat_sh_d;
            valid_d = 1'b1;
            state_d = PUBLISH;
          end
        end else begin
          retry_d = retry_q + 4'd1;
        end
      end
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, shadow and published registers; reset aborts any round.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      retry_q   <= '0;
      ball_sh_q <= '0;
      slot_q    <= '0;
      plat_sh_q <= '0;
      used_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      ball_q    <= '0;
      plat_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      ball_sh_q <= ball_sh_d;
      slot_q    <= slot_d;
      plat_sh_q <= plat_sh_d;
      used_q    <= used_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ball_q    <= ball_d;
      plat_q    <= plat_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_color_round_ctrl.sv
// Scoreboard bench for color_round_ctrl.
// Random byte streams checked against a draw-level reference model.
`timescale 1ns/1ps
module tb_color_round_ctrl;

  localparam int MAX_RETRY = 7;
`ifdef COLOR_DISTINCT_EN
  localparam bit DISTINCT = 1'b1;
`else
  localparam bit DISTINCT = 1'b0;
`endif

  typedef struct {
    logic [2:0]  ball;
    logic [11:0] plat;
    int          n;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        round_req = 1'b0;
  logic [7:0]  rand_in = 8'h00;
  logic        rand_step;
  logic [2:0]  ball_color;
  logic [11:0] plat_colors;
  logic        colors_valid;
  logic        busy;
  logic        round_ack;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  logic [7:0] rb[64];

  color_round_ctrl #(.MAX_RETRY(MAX_RETRY)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .round_req    (round_req),
    .rand_in      (rand_in),
    .rand_step    (rand_step),
    .ball_color   (ball_color),
    .plat_colors  (plat_colors),
    .colors_valid (colors_valid),
    .busy         (busy),
    .round_ack    (round_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic bit legal(input logic [2:0] v, input logic [2:0] b,
                               input logic [7:0] used);
    return (v != 3'd0) && (v != b) && !(DISTINCT && used[v]);
  endfunction

  // Reference: consume rb[] draw by draw, count bytes consumed.
  function automatic exp_t model();
    exp_t       e;
    int         k = 0;
    int         rej = 0;
    logic [2:0] v;
    logic [2:0] b = 3'd0;
    int         slot;
    logic [2:0] pc[4];
    logic [7:0] used = 8'h00;
    while (b == 3'd0) begin
      v = rb[k][2:0];
      k++;
      if (v != 3'd0) b = v;
      else if (rej == MAX_RETRY) b = 3'd1;
      else rej++;
    end
    slot = int'(rb[k][7:6]);
    k++;
    pc[slot] = b;
    for (int s = 0; s < 4; s++) begin
      if (s != slot) begin
        rej = 0;
        pc[s] = 3'd0;
        while (pc[s] == 3'd0) begin
          v = rb[k][5:3];
          k++;
          if (legal(v, b, used)) pc[s] = v;
          else if (rej == MAX_RETRY) begin
            for (int c = 7; c >= 1; c--)
              if (legal(3'(c), b, used)) pc[s] = 3'(c);
          end else rej++;
        end
        if (DISTINCT) used[pc[s]] = 1'b1;
      end
    end
    e.ball = b;
    e.plat = {pc[3], pc[2], pc[1], pc[0]};
    e.n    = k;
    e.acc  = 0;
    return e;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < 64; i++) begin
      case (mode)
        0:       rb[i] = 8'($urandom);
        2:       rb[i] = 8'($urandom) & 8'hC9;
        default: rb[i] = 8'h00;
      endcase
    end
  endtask

  task automatic hard_reset();
    resetn = 1'b0;
    round_req = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    sb.delete();
  endtask

  task automatic run_round(input exp_t e, input bit pulse);
    int k = 0;
    int w = 0;
    @(negedge clk);
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    e.acc = cyc;
    sb.push_back(e);
    round_req = 1'b1;
    forever begin
      @(negedge clk);
      if (k > 0 && !busy) break;
      if (k >= 64) begin
        chk("round_timeout", 32'(busy), 32'd0);
        hard_reset();
        break;
      end
      rand_in   = rb[k];
      round_req = pulse && (k == 2 || k == 3);
      k++;
    end
    round_req = 1'b0;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    round_req = 1'b1;
    @(negedge clk);
    round_req = 1'b0;
    rand_in   = 8'h0B;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_ball", 32'(ball_color), 32'd0);
    chk("arst_plat", 32'(plat_colors), 32'd0);
    chk("arst_valid", 32'(colors_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ack", 32'(round_ack), 32'd0);
    chk("arst_step", 32'(rand_step), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Monitor: pops the scoreboard on each ack, checks holds otherwise.
  initial begin
    logic [2:0]  pb;
    logic [11:0] pp;
    logic        pv;
    int          steps;
    exp_t        e;
    pb = '0;
    pp = '0;
    pv = 1'b0;
    steps = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pb = '0;
        pp = '0;
        pv = 1'b0;
        steps = 0;
      end else begin
        if (rand_step) steps++;
        if (round_ack) begin
          if (sb.size() == 0) begin
            chk("spurious_ack", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("ball", 32'(ball_color), 32'(e.ball));
            chk("plat", 32'(plat_colors), 32'(e.plat));
            chk("ack_cycle", 32'(cyc - e.acc), 32'(e.n + 1));
            chk("step_count", 32'(steps), 32'(e.n));
            chk("ack_valid", 32'(colors_valid), 32'd1);
            chk("ack_busy", 32'(busy), 32'd1);
            pb = e.ball;
            pp = e.plat;
            pv = 1'b1;
          end
          steps = 0;
        end else if (busy) begin
          chk("hold_ball", 32'(ball_color), 32'(pb));
          chk("hold_plat", 32'(plat_colors), 32'(pp));
          chk("hold_valid", 32'(colors_valid), 32'(pv));
        end else begin
          chk("idle_step", 32'(rand_step), 32'd0);
          chk("idle_plat", 32'(plat_colors), 32'(pp));
          chk("idle_valid", 32'(colors_valid), 32'(pv));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   m;
    repeat (3) @(negedge clk);
    chk("rst_ball", 32'(ball_color), 32'd0);
    chk("rst_plat", 32'(plat_colors), 32'd0);
    chk("rst_valid", 32'(colors_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(round_ack), 32'd0);
    chk("rst_step", 32'(rand_step), 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    fill(1);
    rb[0] = 8'h05; rb[1] = 8'h80; rb[2] = 8'h08;
    rb[3] = 8'h10; rb[4] = 8'h18;
    e.ball = 3'd5; e.plat = 12'h751; e.n = 5; e.acc = 0;
    run_round(e, 1'b0);

    fill(1);
    e.ball = 3'd1;
    e.plat = DISTINCT ? 12'h8D1 : 12'h491;
    e.n = 33;
    run_round(e, 1'b0);

    fill(1);
    rb[0] = 8'h05; rb[1] = 8'h00; rb[2] = 8'h28;
    rb[3] = 8'h10; rb[4] = 8'h18; rb[5] = 8'h20;
    e.ball = 3'd5; e.plat = 12'h8D5; e.n = 6;
    run_round(e, 1'b0);

    fill(0);
    run_round(model(), 1'b1);

    for (int i = 0; i < 30; i++) begin
      m = $urandom_range(0, 3);
      fill(m == 3 ? 2 : 0);
      run_round(model(), 1'b0);
    end

    mid_reset();

    for (int i = 0; i < 6; i++) begin
      fill(i[0] ? 2 : 0);
      run_round(model(), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/color_round_ctrl.md
# color_round_ctrl

Sequencer that produces one round's colour assignment for the platform/ball game. On a request from the game FSM it steps the external 8-bit pseudo-random source, draws a non-black ball colour, picks which of the 4 platform slots carries the ball colour, and fills the other slots with non-black colours that differ from the ball. It retries rejected draws, uses a bounded fallback, and publishes all colours atomically with a one-cycle acknowledge. It sits between the game FSM and the random source and drives the VGA platform/ball colour registers.

## Interface
- `MAX_RETRY`, default 7: rejected samples tolerated per draw before the fallback colour is used; legal range 1–15.
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `round_req`  in  1  level request for a new round, sampled only in IDLE.
- `rand_in`  in  8  current pseudo-random value.
- `rand_step`  out  1  enable to the random source; high in every cycle that consumes `rand_in`.
- `ball_color`  out  3  published ball colour.
- `plat_colors`  out  12  published platform colours; slot k occupies bits [3k+2:3k].
- `colors_valid`  out  1  high once any round has been published; stays high until reset.
- `busy`  out  1  high from request accept until the publish cycle, inclusive.
- `round_ack`  out  1  one-cycle pulse in the cycle the new outputs first appear.

## Operation
- States: IDLE → DRAW_BALL → DRAW_SLOT → DRAW_PLAT (visits slots in ascending index, skipping the ball slot, 3 iterations) → PUBLISH → IDLE.
- IDLE: if `round_req`=1, go to DRAW_BALL and clear the retry counter. Otherwise hold.
- DRAW_BALL: candidate = `rand_in[2:0]`. Accept if the candidate is not 0. On reject, increment the retry counter. On the (MAX_RETRY+1)-th rejected sample, accept the fallback 3'b001 in that same cycle.
- DRAW_SLOT: slot = `rand_in[7:6]`. This state always accepts in one cycle.
- DRAW_PLAT: candidate = `rand_in[5:3]`. Accept if the candidate is not 0 and not equal to the ball colour. Apply the further constraint under Configuration when enabled. The retry rule is the same as DRAW_BALL, and the counter clears on every accept. Fallback is the lowest colour in 1..7 that satisfies all active constraints. A legal fallback always exists because 7 colours are available and at most 4 are excluded.
- All draws write shadow registers. Published outputs hold their old values while `busy`=1.
- PUBLISH: copy the shadow registers to the outputs, set `colors_valid`, pulse `round_ack`, then return to IDLE.
- A `round_req` asserted while `busy`=1 is ignored, not queued. If it is still high on return to IDLE, a new round starts the next cycle.

## Timing
- Reset values: `ball_color`=0, `plat_colors`=0, `colors_valid`=0, `busy`=0, `round_ack`=0, `rand_step`=0. The state returns to IDLE and all counters and shadow registers clear.
- `rand_step` is asserted combinationally in DRAW_BALL, DRAW_SLOT and DRAW_PLAT. It is 0 in IDLE and PUBLISH.
- Cycle N samples `round_req`=1 in IDLE. `busy` rises at N+1.
- Best-case round (no rejects): DRAW_BALL at N+1, DRAW_SLOT at N+2, DRAW_PLAT at N+3..N+5, PUBLISH at N+6. New outputs and `round_ack` appear at N+6; `busy` drops at N+7.
- Worst case: 2·(MAX_RETRY+1) + 3·(MAX_RETRY+1) … specifically (MAX_RETRY+1) ball + 1 slot + 3·(MAX_RETRY+1) platform cycles, plus 1 PUBLISH cycle. This is 34 cycles for the default.
- `resetn` asserted mid-round aborts immediately. The shadow contents are discarded and no `round_ack` is produced.

## Configuration
- `COLOR_DISTINCT_EN` defined: each platform candidate must also differ from every platform colour already accepted this round. The fallback honours this constraint as well.
- Not defined: platforms may repeat colours among themselves; they only differ from the ball and from black.

## Structure
- Shared package `color_pkg`:
  - `COLOR_W`=3, `NUM_SLOTS`=4, `COLOR_BLACK`=3'b000.
  - State enum `round_state_t`.
  - Slot index type.
- One combinational sub-module, `color_fallback_pick`:
  - Inputs: candidate, ball colour, used-colour mask.
  - Outputs: accept flag and lowest legal fallback colour.
  - Instantiated once and shared by DRAW_BALL and DRAW_PLAT; the mask is empty in DRAW_BALL.

## Test plan
- Reset, no request → all outputs 0, `rand_step`=0, `busy`=0.
- Request with `rand_in` sequence 0x05, 0x80, 0x08, 0x10, 0x18 → `ball_color`=5, `plat_colors`=0x751, `round_ack` 6 cycles after the request sample, `rand_step` high for exactly 5 cycles.
- Request with `rand_in` held at 0x00, `COLOR_DISTINCT_EN` defined → `ball_color`=1, `plat_colors`=0x8D1, `round_ack` at cycle 34. Without the macro → `plat_colors`=0x491.
- Ball 5, slot 0, platform samples 0x28 (colour 5, rejected), 0x10, 0x18, 0x20 → `plat_colors`={4,3,2,5}=0x8D5, ack one cycle later than best case.
- Pulse `round_req` again during a round, then drop it → ignored; one `round_ack` only; outputs unchanged until PUBLISH.
- `resetn` low during DRAW_PLAT → outputs return to reset values asynchronously; after release, a new request completes normally.
